// File: rtl/hsi_s_rx_ctrl.sv
// Slave-side HSI receive frame controller.
// Parses FLAG, LEN, payload, CRC_HI, CRC_LO from the decoded byte stream,
// forwards payload bytes, checks CRC16-CCITT and reports a good frame
// (rx_frame_end) or a rejected one (rx_err) to the transmit side.

`ifndef FLAG_CONTROL_COMMAND_WORD
`define FLAG_CONTROL_COMMAND_WORD 8'hA5
`endif
`ifndef FLAG_STATUS_REQUEST
`define FLAG_STATUS_REQUEST 8'h5A
`endif
`ifndef FLAG_DATA_PACKET_REQUEST
`define FLAG_DATA_PACKET_REQUEST 8'h3C
`endif

module hsi_s_rx_ctrl #(
  parameter int MAX_LEN     = 64,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_en,
  input  logic [7:0] d,
  input  logic       d_rdy,
  input  logic       dec_err,
  output logic [7:0] rx_flag,
  output logic [7:0] rx_len,
  output logic       rx_frame_end,
  output logic       rx_err,
  output logic [7:0] q,
  output logic       q_rdy,
  output logic       rx_busy
);

  localparam int                  DATA_W   = 8;
  localparam int                  GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0]    GAP_MAX  = GAP_W'(GAP_TIMEOUT);
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [DATA_W-1:0]   LEN_MAX  = DATA_W'(MAX_LEN);
  localparam logic [15:0]         CRC_INIT = 16'hFFFF;
  localparam logic [15:0]         CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CRC_HI,
    S_CRC_LO,
    S_DRAIN
  } state_t;

  state_t              state, state_n;
  logic [15:0]         crc, crc_n, crc_d;
  logic [DATA_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]   flag_r, flag_n;
  logic [DATA_W-1:0]   len_r, len_n;
  logic [GAP_W-1:0]    gap_cnt, gap_n;
  logic                gap_hit;
  logic [DATA_W-1:0]   rx_flag_n, rx_len_n, q_n;
  logic                q_rdy_n, end_n, err_n, busy_n;

  // Byte-wide CRC16-CCITT update, MSB first, no reflection.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [DATA_W-1:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  // Only the three shared flag codes start a frame.
  function automatic logic is_flag(input logic [DATA_W-1:0] b);
    return (b == `FLAG_CONTROL_COMMAND_WORD) ||
           (b == `FLAG_STATUS_REQUEST)       ||
           (b == `FLAG_DATA_PACKET_REQUEST);
  endfunction

  // A byte arriving on the expiry cycle wins, so the hit requires no d_rdy.
  assign gap_hit = clk_en && !d_rdy && (gap_cnt == GAP_LAST);

  // Frame parser: next state, CRC, counters and next output values.
  always_comb begin
    state_n   = state;
    crc_n     = crc;
    cnt_n     = cnt;
    flag_n    = flag_r;
    len_n     = len_r;
    rx_flag_n = rx_flag;
    rx_len_n  = rx_len;
    q_n       = q;
    q_rdy_n   = 1'b0;
    end_n     = 1'b0;
    err_n     = 1'b0;
    crc_d     = crc16_upd(crc, d);

    case (state)
      S_IDLE: begin
        if (d_rdy) begin
          if (is_flag(d)) begin
            flag_n  = d;
            crc_n   = crc16_upd(CRC_INIT, d);
            state_n = S_LEN;
          end else begin
            err_n   = 1'b1;
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (gap_hit) state_n = S_IDLE;
      end
      default: begin
        // Line errors take priority over a coincident byte.
        if (dec_err) begin
          err_n   = 1'b1;
          state_n = S_DRAIN;
        end else if (d_rdy) begin
          case (state)
            S_LEN: begin
              if (d > LEN_MAX) begin
                err_n   = 1'b1;
                state_n = S_DRAIN;
              end else begin
                len_n   = d;
                cnt_n   = d;
                crc_n   = crc_d;
                state_n = (d == 8'd0) ? S_CRC_HI : S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              q_n     = d;
              q_rdy_n = 1'b1;
              crc_n   = crc_d;
              cnt_n   = cnt - 8'd1;
              if (cnt == 8'd1) state_n = S_CRC_HI;
            end
            S_CRC_HI: begin
              crc_n   = crc_d;
              state_n = S_CRC_LO;
            end
            default: begin
              crc_n   = crc_d;
              state_n = S_IDLE;
              if (crc_d == 16'h0000) begin
                rx_flag_n = flag_r;
                rx_len_n  = len_r;
                end_n     = 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end
          endcase
        end else if (gap_hit) begin
          // Line already idle for the full gap: no drain needed.
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
    endcase

    // Gap counter restarts on every byte and on entry to DRAIN.
    if (d_rdy || (state == S_IDLE) || ((state_n == S_DRAIN) && (state != S_DRAIN))) begin
      gap_n = '0;
    end else if (clk_en && (gap_cnt != GAP_MAX)) begin
      gap_n = gap_cnt + GAP_W'(1);
    end else begin
      gap_n = gap_cnt;
    end

    busy_n = state_n inside {S_LEN, S_PAYLOAD, S_CRC_HI, S_CRC_LO};
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      crc          <= CRC_INIT;
      cnt          <= '0;
      flag_r       <= '0;
      len_r        <= '0;
      gap_cnt      <= '0;
      rx_flag      <= '0;
      rx_len       <= '0;
      q            <= '0;
      q_rdy        <= 1'b0;
      rx_frame_end <= 1'b0;
      rx_err       <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_n;
      crc          <= crc_n;
      cnt          <= cnt_n;
      flag_r       <= flag_n;
      len_r        <= len_n;
      gap_cnt      <= gap_n;
      rx_flag      <= rx_flag_n;
      rx_len       <= rx_len_n;
      q            <= q_n;
      q_rdy        <= q_rdy_n;
      rx_frame_end <= end_n;
      rx_err       <= err_n;
      rx_busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_hsi_s_rx_ctrl.sv
// Self-checking bench for hsi_s_rx_ctrl: randomized frames checked against
// a frame-level reference (bitwise CRC over the whole frame, expected
// payload stream and result counts).

`ifndef FLAG_CONTROL_COMMAND_WORD
`define FLAG_CONTROL_COMMAND_WORD 8'hA5
`endif
`ifndef FLAG_STATUS_REQUEST
`define FLAG_STATUS_REQUEST 8'h5A
`endif
`ifndef FLAG_DATA_PACKET_REQUEST
`define FLAG_DATA_PACKET_REQUEST 8'h3C
`endif

module tb_hsi_s_rx_ctrl;

  localparam int MAX_LEN = 64;
  localparam int GAP     = 40;
  localparam logic [7:0] F_CTL = `FLAG_CONTROL_COMMAND_WORD;
  localparam logic [7:0] F_STA = `FLAG_STATUS_REQUEST;
  localparam logic [7:0] F_DAT = `FLAG_DATA_PACKET_REQUEST;

  logic       clk = 1'b0;
  logic       n_rst, clk_en, d_rdy, dec_err;
  logic [7:0] d;
  logic [7:0] rx_flag, rx_len, q;
  logic       rx_frame_end, rx_err, q_rdy, rx_busy;

  hsi_s_rx_ctrl #(.MAX_LEN(MAX_LEN), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .d(d), .d_rdy(d_rdy),
    .dec_err(dec_err), .rx_flag(rx_flag), .rx_len(rx_len),
    .rx_frame_end(rx_frame_end), .rx_err(rx_err), .q(q), .q_rdy(q_rdy),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge.
  logic [7:0] q_log[$];
  int         q_cyc[$];
  int         n_end, n_err, n_both, end_cyc, err_cyc;
  always @(negedge clk) begin
    if (q_rdy) begin q_log.push_back(q); q_cyc.push_back(cyc); end
    if (rx_frame_end) begin n_end++; end_cyc = cyc; end
    if (rx_err) begin n_err++; err_cyc = cyc; end
    if (rx_frame_end && rx_err) n_both++;
  end

  int chk = 0, pass_n = 0;
  int drv_cyc;
  logic [7:0] pl[$];
  logic [7:0] frm[$];
  logic [7:0] m_flag = 8'h00, m_len = 8'h00;

  // Reference CRC: bit-serial polynomial division over the message.
  function automatic logic [15:0] model_crc(input logic [7:0] m[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (m[i]) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = c[15] ^ m[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic bit valid_flag(input logic [7:0] f);
    return (f == F_CTL) || (f == F_STA) || (f == F_DAT);
  endfunction

  // A complete frame is good when flag and length are legal and the CRC over
  // all bytes including the appended CRC leaves a zero residue.
  function automatic bit model_good(input logic [7:0] f[$]);
    if (f.size() < 4) return 1'b0;
    if (!valid_flag(f[0]) || f[1] > 8'(MAX_LEN)) return 1'b0;
    if (f.size() != int'(f[1]) + 4) return 1'b0;
    return model_crc(f) == 16'h0000;
  endfunction

  task automatic make_frame(input logic [7:0] flag, input bit bad_crc);
    logic [15:0] c;
    frm = {};
    frm.push_back(flag);
    frm.push_back(8'(pl.size()));
    foreach (pl[i]) frm.push_back(pl[i]);
    c = model_crc(frm);
    frm.push_back(c[15:8]);
    frm.push_back(bad_crc ? (c[7:0] ^ 8'h01) : c[7:0]);
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    d = b; d_rdy = 1'b1; drv_cyc = cyc;
    @(negedge clk); #1;
    d_rdy = 1'b0;
    repeat (idle) begin @(negedge clk); #1; end
  endtask

  task automatic send_frame(input int idle);
    foreach (frm[i]) send_byte(frm[i], idle);
  endtask

  task automatic clr_mon;
    q_log = {}; q_cyc = {};
    n_end = 0; n_err = 0; n_both = 0; end_cyc = -1; err_cyc = -1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; clk_en = 1'b1; d = 8'h00; d_rdy = 1'b0; dec_err = 1'b0;
    settle(3);
    chk++; if (rx_flag !== 8'h00) $display("FAIL reset_rx_flag got=%h exp=00", rx_flag); else pass_n++;
    chk++; if (rx_len !== 8'h00) $display("FAIL reset_rx_len got=%h exp=00", rx_len); else pass_n++;
    chk++; if (q !== 8'h00) $display("FAIL reset_q got=%h exp=00", q); else pass_n++;
    chk++; if (q_rdy !== 1'b0) $display("FAIL reset_q_rdy got=%b exp=0", q_rdy); else pass_n++;
    chk++; if (rx_frame_end !== 1'b0) $display("FAIL reset_frame_end got=%b exp=0", rx_frame_end); else pass_n++;
    chk++; if (rx_err !== 1'b0) $display("FAIL reset_rx_err got=%b exp=0", rx_err); else pass_n++;
    chk++; if (rx_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", rx_busy); else pass_n++;
    n_rst = 1'b1;
    settle(2);
  endtask

  task automatic test_status;
    int last;
    clr_mon();
    pl = {};
    make_frame(F_STA, 1'b0);
    send_frame(0);
    last = drv_cyc;
    settle(3);
    if (model_good(frm)) begin m_flag = F_STA; m_len = 8'h00; end
    chk++; if (n_end !== 1) $display("FAIL status_end_count got=%0d exp=1", n_end); else pass_n++;
    chk++; if (n_err !== 0) $display("FAIL status_err_count got=%0d exp=0", n_err); else pass_n++;
    chk++; if (q_log.size() !== 0) $display("FAIL status_q_count got=%0d exp=0", q_log.size()); else pass_n++;
    chk++; if (end_cyc !== last + 1) $display("FAIL status_end_latency got=%0d exp=%0d", end_cyc, last + 1); else pass_n++;
    chk++; if (rx_flag !== m_flag) $display("FAIL status_rx_flag got=%h exp=%h", rx_flag, m_flag); else pass_n++;
    chk++; if (rx_len !== m_len) $display("FAIL status_rx_len got=%h exp=%h", rx_len, m_len); else pass_n++;
  endtask

  task automatic test_ctrl_payload;
    int pay_cyc[$];
    bit ok;
    clr_mon();
    pl = {8'h12, 8'h34, 8'h56, 8'h78};
    make_frame(F_CTL, 1'b0);
    send_byte(frm[0], 10);
    chk++; if (rx_busy !== 1'b1) $display("FAIL ctrl_busy_mid got=%b exp=1", rx_busy); else pass_n++;
    send_byte(frm[1], 10);
    for (int i = 2; i < 6; i++) begin
      send_byte(frm[i], 10);
      pay_cyc.push_back(drv_cyc + 1);
    end
    send_byte(frm[6], 10);
    send_byte(frm[7], 0);
    settle(3);
    m_flag = F_CTL; m_len = 8'd4;
    ok = (q_log.size() == 4);
    if (ok) foreach (pl[i]) if (q_log[i] !== pl[i] || q_cyc[i] !== pay_cyc[i]) ok = 0;
    chk++; if (!ok) $display("FAIL ctrl_payload got_n=%0d exp=12 34 56 78 at d_rdy+1", q_log.size()); else pass_n++;
    chk++; if (n_end !== 1 || n_err !== 0) $display("FAIL ctrl_result got=end%0d/err%0d exp=end1/err0", n_end, n_err); else pass_n++;
    chk++; if (rx_len !== m_len) $display("FAIL ctrl_rx_len got=%h exp=%h", rx_len, m_len); else pass_n++;
    chk++; if (rx_flag !== m_flag) $display("FAIL ctrl_rx_flag got=%h exp=%h", rx_flag, m_flag); else pass_n++;
    chk++; if (rx_busy !== 1'b0) $display("FAIL ctrl_busy_end got=%b exp=0", rx_busy); else pass_n++;
  endtask

  task automatic test_bad_crc;
    int last;
    clr_mon();
    pl = {8'h12, 8'h34, 8'h56, 8'h78};
    make_frame(F_DAT, 1'b1);
    send_frame(2);
    last = drv_cyc;
    settle(4);
    chk++; if (n_err !== 1 || err_cyc !== last + 1) $display("FAIL badcrc_err got=%0d@%0d exp=1@%0d", n_err, err_cyc, last + 1); else pass_n++;
    chk++; if (n_end !== 0) $display("FAIL badcrc_end got=%0d exp=0", n_end); else pass_n++;
    chk++; if (rx_flag !== m_flag || rx_len !== m_len) $display("FAIL badcrc_keep got=%h/%h exp=%h/%h", rx_flag, rx_len, m_flag, m_len); else pass_n++;
  endtask

  task automatic test_len_overflow;
    bit ok;
    clr_mon();
    send_byte(F_CTL, 1);
    send_byte(8'(MAX_LEN + 1), 1);
    for (int i = 0; i < 70; i++) send_byte(8'($urandom), $urandom_range(0, 3));
    settle(GAP + 5);
    chk++; if (n_err !== 1) $display("FAIL ovf_err_count got=%0d exp=1", n_err); else pass_n++;
    chk++; if (q_log.size() !== 0) $display("FAIL ovf_junk_fwd got=%0d exp=0", q_log.size()); else pass_n++;
    pl = {};
    for (int i = 0; i < 3; i++) pl.push_back(8'($urandom));
    make_frame(F_DAT, 1'b0);
    send_frame(1);
    settle(3);
    m_flag = F_DAT; m_len = 8'd3;
    ok = (q_log.size() == 3);
    if (ok) foreach (pl[i]) if (q_log[i] !== pl[i]) ok = 0;
    chk++; if (!ok) $display("FAIL ovf_next_payload got_n=%0d exp=3", q_log.size()); else pass_n++;
    chk++; if (n_end !== 1 || n_err !== 1) $display("FAIL ovf_next_result got=end%0d/err%0d exp=end1/err1", n_end, n_err); else pass_n++;
    chk++; if (rx_flag !== m_flag) $display("FAIL ovf_next_flag got=%h exp=%h", rx_flag, m_flag); else pass_n++;
  endtask

  task automatic test_timeout;
    int en_cnt, exp_cyc;
    clr_mon();
    send_byte(F_CTL, 1);
    send_byte(8'd3, 1);
    send_byte(8'h5E, 0);
    en_cnt = 0; exp_cyc = -1;
    // Half-rate enable: the limit counts enabled cycles only.
    for (int k = 0; k < 2 * GAP + 6; k++) begin
      clk_en = (k % 2 == 0);
      if (clk_en) begin
        en_cnt++;
        if (en_cnt == GAP) exp_cyc = cyc + 1;
      end
      @(negedge clk); #1;
    end
    clk_en = 1'b1;
    chk++; if (n_err !== 1 || err_cyc !== exp_cyc) $display("FAIL timeout_err got=%0d@%0d exp=1@%0d", n_err, err_cyc, exp_cyc); else pass_n++;
    chk++; if (n_end !== 0) $display("FAIL timeout_end got=%0d exp=0", n_end); else pass_n++;
    chk++; if (rx_busy !== 1'b0) $display("FAIL timeout_busy got=%b exp=0", rx_busy); else pass_n++;
    chk++; if (q_log.size() !== 1 || q_log[0] !== 8'h5E) $display("FAIL timeout_q got_n=%0d exp=1 byte 5e", q_log.size()); else pass_n++;
  endtask

  task automatic test_gap_boundary;
    clr_mon();
    pl = {8'($urandom), 8'($urandom)};
    make_frame(F_STA, 1'b0);
    // Each byte lands exactly on the cycle the gap limit would expire.
    send_frame(GAP - 1);
    settle(3);
    m_flag = F_STA; m_len = 8'd2;
    chk++; if (n_end !== 1 || n_err !== 0) $display("FAIL gap_edge_result got=end%0d/err%0d exp=end1/err0", n_end, n_err); else pass_n++;
    chk++; if (rx_len !== m_len) $display("FAIL gap_edge_len got=%h exp=%h", rx_len, m_len); else pass_n++;
  endtask

  task automatic test_bad_flag;
    logic [7:0] b;
    int last;
    clr_mon();
    do b = 8'($urandom); while (valid_flag(b));
    send_byte(b, 0);
    last = drv_cyc;
    settle(2);
    chk++; if (n_err !== 1 || err_cyc !== last + 1) $display("FAIL badflag_err got=%0d@%0d exp=1@%0d", n_err, err_cyc, last + 1); else pass_n++;
    chk++; if (rx_busy !== 1'b0) $display("FAIL badflag_busy got=%b exp=0", rx_busy); else pass_n++;
    settle(GAP + 2);
    pl = {8'h01};
    make_frame(F_CTL, 1'b0);
    send_frame(0);
    settle(3);
    m_flag = F_CTL; m_len = 8'd1;
    chk++; if (n_end !== 1 || rx_flag !== m_flag) $display("FAIL badflag_next got=end%0d flag=%h exp=end1 flag=%h", n_end, rx_flag, m_flag); else pass_n++;
  endtask

  task automatic test_dec_err;
    int last;
    clr_mon();
    pl = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    make_frame(F_CTL, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(frm[i], 2);
    dec_err = 1'b1;
    send_byte(frm[4], 0);
    dec_err = 1'b0;
    last = drv_cyc;
    settle(3);
    chk++; if (n_err !== 1 || err_cyc !== last + 1) $display("FAIL decerr_err got=%0d@%0d exp=1@%0d", n_err, err_cyc, last + 1); else pass_n++;
    chk++; if (q_log.size() !== 2) $display("FAIL decerr_not_fwd got_n=%0d exp=2", q_log.size()); else pass_n++;
    chk++; if (n_end !== 0 || rx_flag !== m_flag) $display("FAIL decerr_keep got=end%0d flag=%h exp=end0 flag=%h", n_end, rx_flag, m_flag); else pass_n++;
    settle(GAP + 3);
    pl = {8'h77};
    make_frame(F_DAT, 1'b0);
    send_frame(1);
    settle(3);
    m_flag = F_DAT; m_len = 8'd1;
    chk++; if (n_end !== 1 || n_err !== 1) $display("FAIL decerr_next got=end%0d/err%0d exp=end1/err1", n_end, n_err); else pass_n++;
    chk++; if (rx_flag !== m_flag) $display("FAIL decerr_next_flag got=%h exp=%h", rx_flag, m_flag); else pass_n++;
  endtask

  task automatic test_reset_mid;
    clr_mon();
    pl = {8'h81, 8'h93, 8'hA5, 8'hB7, 8'hC9};
    make_frame(F_CTL, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(frm[i], 1);
    n_rst = 1'b0;
    #1;
    m_flag = 8'h00; m_len = 8'h00;
    chk++; if (q !== 8'h00 || q_rdy !== 1'b0) $display("FAIL rstmid_q got=%h/%b exp=00/0", q, q_rdy); else pass_n++;
    chk++; if (rx_flag !== 8'h00 || rx_len !== 8'h00) $display("FAIL rstmid_regs got=%h/%h exp=00/00", rx_flag, rx_len); else pass_n++;
    chk++; if (rx_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", rx_busy); else pass_n++;
    settle(2);
    n_rst = 1'b1;
    settle(2);
    chk++; if (n_end !== 0 || n_err !== 0) $display("FAIL rstmid_pulse got=end%0d/err%0d exp=0/0", n_end, n_err); else pass_n++;
    pl = {};
    make_frame(F_STA, 1'b0);
    send_frame(0);
    settle(3);
    m_flag = F_STA; m_len = 8'd0;
    chk++; if (n_end !== 1 || rx_flag !== m_flag) $display("FAIL rstmid_next got=end%0d flag=%h exp=end1 flag=%h", n_end, rx_flag, m_flag); else pass_n++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] stream[$];
    logic [7:0] exp_q[$];
    logic [7:0] flags[3];
    int exp_end, exp_err;
    bit ok;
    flags[0] = F_CTL; flags[1] = F_STA; flags[2] = F_DAT;
    clr_mon();
    exp_end = 0; exp_err = 0;
    for (int f = 0; f < 8; f++) begin
      pl = {};
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) pl.push_back(8'($urandom));
      make_frame(flags[$urandom_range(0, 2)], ($urandom_range(0, 3) == 0));
      foreach (pl[i]) exp_q.push_back(pl[i]);
      if (model_good(frm)) begin exp_end++; m_flag = frm[0]; m_len = frm[1]; end
      else exp_err++;
      foreach (frm[i]) stream.push_back(frm[i]);
    end
    foreach (stream[i]) send_byte(stream[i], 0);
    settle(3);
    ok = (q_log.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (q_log[i] !== exp_q[i]) ok = 0;
    chk++; if (!ok) $display("FAIL b2b_payload got_n=%0d exp_n=%0d", q_log.size(), exp_q.size()); else pass_n++;
    chk++; if (n_end !== exp_end) $display("FAIL b2b_end_count got=%0d exp=%0d", n_end, exp_end); else pass_n++;
    chk++; if (n_err !== exp_err) $display("FAIL b2b_err_count got=%0d exp=%0d", n_err, exp_err); else pass_n++;
    chk++; if (rx_flag !== m_flag || rx_len !== m_len) $display("FAIL b2b_last_good got=%h/%h exp=%h/%h", rx_flag, rx_len, m_flag, m_len); else pass_n++;
    chk++; if (n_both !== 0) $display("FAIL b2b_exclusive got=%0d exp=0", n_both); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_status();
    test_ctrl_payload();
    test_bad_crc();
    test_len_overflow();
    test_timeout();
    test_gap_boundary();
    test_bad_flag();
    test_dec_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, chk);
    $finish;
  end

endmodule
